// File: rtl/wd_job_arbiter_if.sv
// Requester, WD core and response signals of the WD job arbiter.
// The slave modport is the arbiter; master is the surrounding host/core/consumer side.
interface wd_job_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_last;
    logic [33:0] req_data;

    logic        core_in_valid;
    logic [4:0]  core_keyboard;
    logic [4:0]  core_answer;
    logic [3:0]  core_weight;
    logic [2:0]  core_match_target;
    logic        core_out_valid;
    logic [4:0]  core_result;
    logic [10:0] core_out_value;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic        rsp_err;
    logic [4:0]  rsp_result;
    logic [10:0] rsp_value;

    modport master (
        output req_valid, req_last, req_data, core_out_valid, core_result, core_out_value,
               rsp_ready,
        input  req_ready, core_in_valid, core_keyboard, core_answer, core_weight,
               core_match_target, rsp_valid, rsp_id, rsp_err, rsp_result, rsp_value
    );

    modport slave (
        input  req_valid, req_last, req_data, core_out_valid, core_result, core_out_value,
               rsp_ready,
        output req_ready, core_in_valid, core_keyboard, core_answer, core_weight,
               core_match_target, rsp_valid, rsp_id, rsp_err, rsp_result, rsp_value
    );
endinterface

// File: rtl/wd_job_arbiter.sv
// Round-robin sharing of one WD core between two framed requesters: buffer a frame, replay it
// as one contiguous burst, then return the core result (or a timeout error) to the owner.
module wd_job_arbiter #(
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned TIMEOUT   = 1023,
    parameter int unsigned CW        = 10
) (
    input  logic            clk,
    input  logic            rst,
    wd_job_arbiter_if.slave bus,
    output logic            busy
);
    localparam int unsigned IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned LW = $clog2(FRAME_LEN + 1);
    localparam logic [IW-1:0] LastIdx    = IW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] TimeoutVal = CW'(TIMEOUT);

    typedef enum logic [2:0] {StIdle, StCollect, StIssue, StWait, StResp} state_e;

    state_e        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] len_q, len_d;
    logic [CW-1:0] timer_q, timer_d;
    logic          core_in_valid_q, core_in_valid_d;
    logic [16:0]   core_beat_q, core_beat_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_id_q, rsp_id_d;
    logic          rsp_err_q, rsp_err_d;
    logic [4:0]    rsp_result_q, rsp_result_d;
    logic [10:0]   rsp_value_q, rsp_value_d;
    logic [16:0]   frame_q [FRAME_LEN];
    logic          frame_we;
    logic [16:0]   beat_in;

    assign beat_in = grant_q ? bus.req_data[33:17] : bus.req_data[16:0];

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_grant_d    = last_grant_q;
        cnt_d           = cnt_q;
        len_d           = len_q;
        timer_d         = timer_q;
        core_in_valid_d = 1'b0;
        core_beat_d     = '0;
        rsp_valid_d     = rsp_valid_q;
        rsp_id_d        = rsp_id_q;
        rsp_err_d       = rsp_err_q;
        rsp_result_d    = rsp_result_q;
        rsp_value_d     = rsp_value_q;
        frame_we        = 1'b0;
        bus.req_ready   = 2'b00;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (|bus.req_valid) begin
                    // Under contention the requester not served last wins.
                    grant_d = (bus.req_valid == 2'b11) ? ~last_grant_q : bus.req_valid[1];
                    state_d = StCollect;
                end
            end
            StCollect: begin
                bus.req_ready = grant_q ? 2'b10 : 2'b01;
                if (bus.req_valid[grant_q]) begin
                    frame_we = 1'b1;
                    if (bus.req_last[grant_q] || cnt_q == LastIdx) begin
                        len_d   = LW'(cnt_q) + LW'(1);
                        cnt_d   = '0;
                        state_d = StIssue;
                    end else begin
                        cnt_d = cnt_q + IW'(1);
                    end
                end
            end
            StIssue: begin
                core_in_valid_d = 1'b1;
                core_beat_d     = frame_q[cnt_q];
                if (LW'(cnt_q) + LW'(1) == len_q) begin
                    cnt_d   = '0;
                    timer_d = '0;
                    state_d = StWait;
                end else begin
                    cnt_d = cnt_q + IW'(1);
                end
            end
            StWait: begin
                // Core data beats the timeout when both land in the same cycle.
                if (bus.core_out_valid) begin
                    rsp_valid_d  = 1'b1;
                    rsp_id_d     = grant_q;
                    rsp_err_d    = 1'b0;
                    rsp_result_d = bus.core_result;
                    rsp_value_d  = bus.core_out_value;
                    state_d      = StResp;
                end else if (timer_q == TimeoutVal) begin
                    rsp_valid_d  = 1'b1;
                    rsp_id_d     = grant_q;
                    rsp_err_d    = 1'b1;
                    rsp_result_d = '0;
                    rsp_value_d  = '0;
                    state_d      = StResp;
                end else begin
                    timer_d = timer_q + CW'(1);
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    rsp_id_d     = 1'b0;
                    rsp_err_d    = 1'b0;
                    rsp_result_d = '0;
                    rsp_value_d  = '0;
                    last_grant_d = grant_q;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            grant_q         <= 1'b0;
            last_grant_q    <= 1'b1;
            cnt_q           <= '0;
            len_q           <= '0;
            timer_q         <= '0;
            core_in_valid_q <= 1'b0;
            core_beat_q     <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_id_q        <= 1'b0;
            rsp_err_q       <= 1'b0;
            rsp_result_q    <= '0;
            rsp_value_q     <= '0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            last_grant_q    <= last_grant_d;
            cnt_q           <= cnt_d;
            len_q           <= len_d;
            timer_q         <= timer_d;
            core_in_valid_q <= core_in_valid_d;
            core_beat_q     <= core_beat_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_id_q        <= rsp_id_d;
            rsp_err_q       <= rsp_err_d;
            rsp_result_q    <= rsp_result_d;
            rsp_value_q     <= rsp_value_d;
        end
    end

    always_ff @(posedge clk) begin
        if (frame_we) begin
            frame_q[cnt_q] <= beat_in;
        end
    end

    assign bus.core_in_valid = core_in_valid_q;
    assign {bus.core_keyboard, bus.core_answer, bus.core_weight, bus.core_match_target} =
        core_beat_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_value  = rsp_value_q;
    assign busy           = (state_q != StIdle);
endmodule

// File: tb/tb_wd_job_arbiter.sv
// Randomized frames from both requesters checked against a job-level model: round-robin order
// from frame counts, replayed bursts, response timing/payload, timeout and reset behaviour.
module tb_wd_job_arbiter;
    localparam int unsigned FRAME_LEN = 8;
    localparam int unsigned TIMEOUT   = 1023;
    localparam int unsigned CW        = 10;
    localparam int MAX_FRM  = 8;
    localparam int WAIT_MAX = 5000;
    localparam int RUN_MAX  = 12000;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    wd_job_arbiter_if bus ();

    wd_job_arbiter #(
        .FRAME_LEN(FRAME_LEN),
        .TIMEOUT  (TIMEOUT),
        .CW       (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rv [2];
    logic        rl [2];
    logic [16:0] rd [2];
    logic        ov;
    logic [4:0]  cres;
    logic [10:0] cval;
    logic        rr;

    assign bus.req_valid      = {rv[1], rv[0]};
    assign bus.req_last       = {rl[1], rl[0]};
    assign bus.req_data       = {rd[1], rd[0]};
    assign bus.core_out_valid = ov;
    assign bus.core_result    = cres;
    assign bus.core_out_value = cval;
    assign bus.rsp_ready      = rr;

    logic [16:0] beat_mem [2][MAX_FRM][FRAME_LEN];
    int          flen     [2][MAX_FRM];
    bit          use_last [2][MAX_FRM];
    int          nfrm     [2];
    int          served   [2];
    int          exp_order [$];
    int          job;
    int          close_cyc;
    int          tmo_job, tie_job, hold_job, dir_job;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_core"}, {bus.core_in_valid, bus.core_keyboard, bus.core_answer,
                                  bus.core_weight, bus.core_match_target}, 0);
        check_eq({tag, "_rsp"}, {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_result,
                                 bus.rsp_value}, 0);
        check_eq({tag, "_ctl"}, {busy, bus.req_ready}, 0);
    endtask

    // Grant order follows from how many frames each requester still holds.
    function automatic void build_order();
        int rem0 = nfrm[0];
        int rem1 = nfrm[1];
        int lg = 1;
        int g;
        exp_order.delete();
        while (rem0 + rem1 > 0) begin
            if (rem0 > 0 && rem1 > 0) g = 1 - lg;
            else g = (rem0 > 0) ? 0 : 1;
            exp_order.push_back(g);
            if (g == 1) rem1--;
            else rem0--;
            lg = g;
        end
    endfunction

    function automatic void make_frame(input int r, input int f, input int len, input bit lst);
        flen[r][f] = len;
        use_last[r][f] = (len < FRAME_LEN) ? 1'b1 : lst;
        for (int b = 0; b < FRAME_LEN; b++) beat_mem[r][f][b] = 17'($urandom);
    endfunction

    function automatic void make_directed_frame();
        flen[0][0] = FRAME_LEN;
        use_last[0][0] = 1'b1;
        for (int b = 0; b < FRAME_LEN; b++) beat_mem[0][0][b] = {5'(b), 5'h1A, 4'h3, 3'h2};
    endfunction

    task automatic drive_req(input int r);
        int n;
        for (int f = 0; f < nfrm[r]; f++) begin
            for (int b = 0; b < flen[r][f]; b++) begin
                if (b > 0) begin
                    repeat ($urandom_range(0, 2)) begin
                        rv[r] = 1'b0;
                        rd[r] = 17'($urandom);
                        @(posedge clk);
                        #1;
                    end
                end
                rv[r] = 1'b1;
                rd[r] = beat_mem[r][f][b];
                rl[r] = (b == flen[r][f] - 1) && use_last[r][f];
                n = 0;
                @(negedge clk);
                while (!bus.req_ready[r] && n < WAIT_MAX) begin
                    n++;
                    @(negedge clk);
                end
                if (n >= WAIT_MAX) begin
                    check_eq("req_accept", bus.req_ready[r], 1);
                    rv[r] = 1'b0;
                    return;
                end
                if (b == flen[r][f] - 1) close_cyc = cyc;
                @(posedge clk);
                #1;
            end
        end
        rv[r] = 1'b0;
        rl[r] = 1'b0;
    endtask

    // Core model, response consumer and scoreboard; the final beat of a burst is presented in
    // the first WAIT cycle, so a silent core errors out TIMEOUT+1 cycles after that beat.
    task automatic run_monitor();
        bit          in_burst = 0;
        bit          pend = 0;
        bit          rsp_prev = 0;
        int          burst_n = 0;
        int          last_in = 0;
        int          ov_cyc = -1;
        int          exp_cyc = 0;
        int          hold_left = 0;
        int          own = 0;
        int          start = cyc;
        logic [17:0] exp_rsp = '0;
        logic [17:0] held = '0;
        logic [17:0] got;
        logic        nxt_ov;
        logic [4:0]  res;
        logic [10:0] val;
        job = 0;
        served[0] = 0;
        served[1] = 0;
        while (job < exp_order.size() && cyc - start < RUN_MAX) begin
            @(negedge clk);
            own = exp_order[job];
            check_eq("ready_not_both", bus.req_ready == 2'b11, 0);
            if (bus.core_in_valid) begin
                if (!in_burst) begin
                    in_burst = 1;
                    burst_n = 0;
                    check_eq("issue_latency", cyc - close_cyc, 2);
                end
                if (burst_n < flen[own][served[own]])
                    check_eq("core_beat", {bus.core_keyboard, bus.core_answer, bus.core_weight,
                                           bus.core_match_target},
                             beat_mem[own][served[own]][burst_n]);
                burst_n++;
                last_in = cyc;
            end else begin
                check_eq("core_idle_zero", {bus.core_keyboard, bus.core_answer, bus.core_weight,
                                            bus.core_match_target}, 0);
                if (in_burst) begin
                    in_burst = 0;
                    check_eq("burst_len", burst_n, flen[own][served[own]]);
                    pend = 1;
                    if (job == tmo_job) begin
                        ov_cyc = -1;
                        exp_rsp = {own[0], 1'b1, 5'h0, 11'h0};
                        exp_cyc = last_in + TIMEOUT + 1;
                    end else begin
                        res = 5'($urandom);
                        val = 11'($urandom);
                        if (job == tie_job) ov_cyc = last_in + TIMEOUT;
                        else if (job == dir_job) begin
                            ov_cyc = last_in + 4;
                            res = 5'h15;
                            val = 11'h2A7;
                        end else ov_cyc = last_in + 2 + $urandom_range(0, 5);
                        exp_rsp = {own[0], 1'b0, res, val};
                        exp_cyc = ov_cyc + 1;
                    end
                    if (job == hold_job) hold_left = 10;
                end
            end
            if (bus.rsp_valid) begin
                got = {bus.rsp_id, bus.rsp_err, bus.rsp_result, bus.rsp_value};
                if (!rsp_prev) begin
                    check_eq("rsp_expected", pend, 1);
                    check_eq("rsp_cycle", cyc, exp_cyc);
                    check_eq("rsp_payload", got, exp_rsp);
                    pend = 0;
                end else begin
                    check_eq("rsp_stable", got, held);
                end
                check_eq("rsp_busy_ready", {busy, bus.req_ready}, 3'b100);
                held = got;
                if (hold_left > 0) hold_left--;
                if (bus.rsp_ready) begin
                    served[own]++;
                    job++;
                    rsp_prev = 0;
                end else begin
                    rsp_prev = 1;
                end
            end else begin
                rsp_prev = 0;
            end
            nxt_ov = 1'b0;
            if (pend && ov_cyc == cyc + 1) nxt_ov = 1'b1;
            else if (!pend && !in_burst && (!busy || bus.req_ready != 2'b00 || bus.rsp_valid)
                     && $urandom_range(0, 9) == 0) nxt_ov = 1'b1;
            @(posedge clk);
            #1;
            ov = nxt_ov;
            cres = 5'($urandom);
            cval = 11'($urandom);
            if (nxt_ov && pend) begin
                cres = exp_rsp[15:11];
                cval = exp_rsp[10:0];
            end
            rr = (hold_left > 0) ? 1'b0 : 1'($urandom_range(0, 1));
        end
        check_eq("jobs_done", job, exp_order.size());
        ov = 1'b0;
        rr = 1'b0;
    endtask

    initial begin
        int rsp_cnt;
        rst = 1'b1;
        rv[0] = 1'b0; rv[1] = 1'b0;
        rl[0] = 1'b0; rl[1] = 1'b0;
        rd[0] = '0;   rd[1] = '0;
        ov = 1'b0; cres = '0; cval = '0; rr = 1'b0;
        close_cyc = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Both requesters busy from the start: strict alternation with mixed frame shapes.
        nfrm[0] = 6;
        nfrm[1] = 6;
        for (int r = 0; r < 2; r++)
            for (int f = 0; f < 6; f++)
                make_frame(r, f, (f == 0) ? FRAME_LEN : $urandom_range(1, FRAME_LEN),
                           1'($urandom_range(0, 1)));
        make_frame(1, 1, 3, 1'b1);
        build_order();
        hold_job = 1;
        tmo_job  = 2;
        tie_job  = 5;
        dir_job  = -1;
        fork
            drive_req(0);
            drive_req(1);
            run_monitor();
        join

        // Reset while the fourth beat is on the core: no response may follow.
        nfrm[0] = 1;
        nfrm[1] = 0;
        make_directed_frame();
        fork
            drive_req(0);
            begin
                int seen = 0;
                int n = 0;
                while (seen < 4 && n < 500) begin
                    @(negedge clk);
                    n++;
                    if (bus.core_in_valid) seen++;
                end
                check_eq("issue_reached", seen, 4);
                rst = 1'b1;
                @(negedge clk);
                check_reset_outputs("mid_issue_reset");
                rst = 1'b0;
            end
        join
        rsp_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.rsp_valid) rsp_cnt++;
        end
        check_eq("no_rsp_after_rst", rsp_cnt, 0);
        check_eq("idle_after_rst", busy, 0);

        // Fresh frame from req0 after the reset completes with the directed core result.
        build_order();
        hold_job = -1;
        tmo_job  = -1;
        tie_job  = -1;
        dir_job  = 0;
        fork
            drive_req(0);
            run_monitor();
        join

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
